// File: rtl/spi_master.sv
// Serial loader for a block-cipher responder: shifts msg then key out LSB first on SIMO,
// then (when SPI_MASTER_READBACK_EN is defined) reads a 128-bit block back on SOMI.
module spi_master #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [127:0]      msg_in,
    input  logic [Nk*32-1:0]  key_in,
    input  logic              SOMI,
    output logic              SIMO,
    output logic              CSS,
    output logic              mode,
    output logic [127:0]      result,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MSG_BITS = 128;
    localparam int unsigned KEY_BITS = Nk * 32;
    localparam int unsigned TX_BITS  = MSG_BITS + KEY_BITS;
    localparam int unsigned GAP_CYC  = 2;
    localparam int unsigned CNT_W    = (KEY_BITS > 256) ? 9 : 8;

    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BITS - 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    // Round count is carried only so system-level parameter sets stay uniform.
    localparam int unsigned unused_nr = Nr;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSG,
        S_KEY,
        S_GAP,
        S_READ,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TX_BITS-1:0] tx_sr_q;
    logic               armed_q;
    logic               css_q;
    logic               mode_q;
    logic               busy_q;
    logic               done_q;

    // tx_sr shifts in zeros, so it is empty (SIMO=0) everywhere outside MSG/KEY.
    assign SIMO = tx_sr_q[0];
    assign CSS  = css_q;
    assign mode = mode_q;
    assign busy = busy_q;
    assign done = done_q;

    // Transaction sequencer; armed_q blocks a start seen on the reset-release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tx_sr_q <= '0;
            armed_q <= 1'b0;
            css_q   <= 1'b1;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && armed_q) begin
                        state_q <= S_MSG;
                        cnt_q   <= '0;
                        tx_sr_q <= {key_in, msg_in};
                        css_q   <= 1'b0;
                        mode_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_MSG: begin
                    tx_sr_q <= tx_sr_q >> 1;
                    if (cnt_q == MSG_LAST) begin
                        state_q <= S_KEY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_KEY: begin
                    tx_sr_q <= tx_sr_q >> 1;
                    if (cnt_q == KEY_LAST) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                        mode_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
`ifdef SPI_MASTER_READBACK_EN
                        state_q <= S_READ;
`else
                        state_q <= S_DONE;
                        css_q   <= 1'b1;
                        mode_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef SPI_MASTER_READBACK_EN
                S_READ: begin
                    if (cnt_q == MSG_LAST) begin
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                        css_q   <= 1'b1;
                        mode_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_READBACK_EN
    logic [126:0] rx_sr_q;
    logic [127:0] result_q;

    // Bit k is SOMI at the end of READ cycle k; result only moves on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr_q  <= '0;
            result_q <= '0;
        end else if (state_q == S_READ) begin
            rx_sr_q <= {SOMI, rx_sr_q[126:1]};
            if (cnt_q == MSG_LAST) begin
                result_q <= {SOMI, rx_sr_q};
            end
        end
    end

    assign result = result_q;
`else
    logic unused_somi;

    assign unused_somi = SOMI;
    assign result      = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: Nk=4 and Nk=8 instances run the same transactions
// against a responder model; a monitor checks each CSS-low window against the queue.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int unsigned NK_A = 4;
    localparam int unsigned NK_B = 8;
`ifdef SPI_MASTER_READBACK_EN
    localparam int unsigned RB_CYC = 128;
`else
    localparam int unsigned RB_CYC = 0;
`endif
    localparam int unsigned WIN_A  = 128 + NK_A * 32 + 2 + RB_CYC;
    localparam int unsigned WIN_B  = 128 + NK_B * 32 + 2 + RB_CYC;
    localparam int          NTXN   = 8;

    typedef struct {
        logic [127:0] msg;
        logic [255:0] key;
        logic [127:0] resp;
    } exp_t;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic [1:0]       start_w  = 2'b00;
    logic [127:0]     msg_in   = '0;
    logic [255:0]     key_in   = '0;
    logic [127:0]     resp_cur = '0;
    logic [1:0]       somi_w   = 2'b00;
    logic [1:0]       simo_w, css_w, mode_w, busy_w, done_w;
    logic [1:0][127:0] res_w;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_exp = 0;
    int   n_done[2];

    always #5 clk = ~clk;

    spi_master #(.Nk(NK_A), .Nr(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .msg_in(msg_in),
        .key_in(key_in[255:128]), .SOMI(somi_w[0]), .SIMO(simo_w[0]), .CSS(css_w[0]),
        .mode(mode_w[0]), .result(res_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    spi_master #(.Nk(NK_B), .Nr(14)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .msg_in(msg_in),
        .key_in(key_in), .SOMI(somi_w[1]), .SIMO(simo_w[1]), .CSS(css_w[1]),
        .mode(mode_w[1]), .result(res_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: SIMO carries the message then the key, each LSB first.
    function automatic logic [511:0] exp_stream(input int d, input exp_t e);
        if (d == 0) return 512'({e.key[255:128], e.msg});
        return 512'({e.key, e.msg});
    endfunction

    function automatic logic [127:0] exp_result(input exp_t e);
        return (RB_CYC != 0) ? e.resp : 128'h0;
    endfunction

    // Responder: after the two settle cycles, READ cycle k carries resp bit k; noise elsewhere.
    int mcnt[2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (css_w[d] == 1'b0 && mode_w[d] == 1'b1) begin
                mcnt[d]++;
                if (mcnt[d] >= 3 && mcnt[d] <= 130) somi_w[d] = resp_cur[mcnt[d] - 3];
                else somi_w[d] = 1'($urandom);
            end else begin
                mcnt[d]   = 0;
                somi_w[d] = 1'($urandom);
            end
        end
    end

    // Monitor: collect each CSS-low window, compare at the DONE cycle.
    int           win_len[2], nbits[2], mode_hi[2];
    bit           active[2];
    bit   [3:0]   bad[2];
    logic [511:0] strm[2];
    logic [127:0] last_res[2];
    exp_t         me;
    int           msz;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                active[d]   = 1'b0;
                last_res[d] = '0;
            end else if (css_w[d] == 1'b0) begin
                if (!active[d]) begin
                    active[d]  = 1'b1;
                    win_len[d] = 0;
                    nbits[d]   = 0;
                    mode_hi[d] = 0;
                    strm[d]    = '0;
                    bad[d]     = '0;
                end
                win_len[d]++;
                if (mode_w[d] == 1'b0) begin
                    if (mode_hi[d] != 0) bad[d][0] = 1'b1;
                    if (nbits[d] < 512) strm[d][nbits[d]] = simo_w[d];
                    nbits[d]++;
                end else begin
                    mode_hi[d]++;
                    if (simo_w[d] !== 1'b0) bad[d][1] = 1'b1;
                end
                if (busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) bad[d][2] = 1'b1;
                if (res_w[d] !== last_res[d]) bad[d][3] = 1'b1;
            end else if (active[d]) begin
                active[d] = 1'b0;
                n_done[d]++;
                msz = (d == 0) ? sb_a.size() : sb_b.size();
                if (msz == 0) begin
                    check($sformatf("dut%0d_unexpected_txn", d), 512'(msz), 512'(1));
                end else begin
                    if (d == 0) me = sb_a.pop_front();
                    else        me = sb_b.pop_front();
                    check($sformatf("dut%0d_css_len", d), 512'(win_len[d]),
                          512'((d == 0) ? WIN_A : WIN_B));
                    check($sformatf("dut%0d_simo_bits", d), 512'(nbits[d]),
                          512'(128 + ((d == 0) ? NK_A : NK_B) * 32));
                    check($sformatf("dut%0d_simo_stream", d), strm[d], exp_stream(d, me));
                    check($sformatf("dut%0d_mode_hi", d), 512'(mode_hi[d]), 512'(2 + RB_CYC));
                    check($sformatf("dut%0d_result", d), 512'(res_w[d]), 512'(exp_result(me)));
                    check($sformatf("dut%0d_done_busy", d), 512'({done_w[d], busy_w[d]}), 512'(2'b10));
                    check($sformatf("dut%0d_window_flags", d), 512'(bad[d]), 512'(0));
                    last_res[d] = exp_result(me);
                end
            end else begin
                check($sformatf("dut%0d_idle", d), 512'({done_w[d], busy_w[d], simo_w[d], mode_w[d], res_w[d]}),
                      512'({4'b0000, last_res[d]}));
            end
        end
    end

    task automatic wait_done_pulse(input int d, input int budget);
        int t = 0;
        while (done_w[d] !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("dut%0d_done_wait", d), 512'(t < budget), 512'(1));
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((n_done[0] != n_exp || n_done[1] != n_exp) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("txn_complete_wait", 512'(t < budget), 512'(1));
    endtask

    task automatic run_txn(input logic [127:0] m, input logic [255:0] k, input logic [127:0] r,
                           input int glitch, input bit done_glitch);
        exp_t e;
        e.msg = m; e.key = k; e.resp = r;
        @(negedge clk);
        msg_in = m; key_in = k; resp_cur = r; start_w = 2'b11;
        sb_a.push_back(e); sb_b.push_back(e); n_exp++;
        @(negedge clk);
        start_w = 2'b00;
        msg_in  = rnd128();
        key_in  = {rnd128(), rnd128()};
        if (glitch > 0) begin
            repeat (glitch) @(negedge clk);
            start_w = 2'b11;
            @(negedge clk);
            start_w = 2'b00;
        end
        if (done_glitch) begin
            wait_done_pulse(0, 2 * WIN_B);
            start_w = 2'b01;
            @(negedge clk);
            start_w = 2'b00;
            wait_done_pulse(1, 2 * WIN_B);
            start_w = 2'b10;
            @(negedge clk);
            start_w = 2'b00;
        end
        wait_idle(4 * WIN_B);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_done[0] = 0; n_done[1] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 512'({css_w, busy_w, done_w, mode_w, simo_w}), 512'(10'b11_00_00_00_00));
        check("reset_result", 512'(res_w), 512'(0));

        // Start held across the reset-release edge must be dropped.
        start_w = 2'b11;
        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_w = 2'b00;
        repeat (3) @(negedge clk);
        check("start_at_release", 512'({css_w, busy_w}), 512'(4'b11_00));

        // Known-answer block, with ignored starts during MSG cycle 50 and at DONE.
        run_txn(128'h00112233445566778899aabbccddeeff,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 50, 1'b1);

        run_txn({128{1'b1}}, '0, {64{2'b10}}, 0, 1'b0);
        run_txn('0, {256{1'b1}}, {64{2'b01}}, 0, 1'b0);
        for (int i = 0; i < NTXN; i++) begin
            run_txn(rnd128(), {rnd128(), rnd128()}, rnd128(),
                    (i % 2 == 1) ? int'($urandom_range(1, WIN_A - 1)) : 0, 1'b0);
        end

        // Asynchronous reset at KEY cycle 10 of the Nk=4 instance.
        @(negedge clk);
        msg_in = rnd128(); key_in = {rnd128(), rnd128()}; resp_cur = rnd128(); start_w = 2'b11;
        @(negedge clk);
        start_w = 2'b00;
        repeat (128 + 10) @(negedge clk);
        check("pre_reset_active", 512'({css_w, busy_w}), 512'(4'b00_11));
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", 512'({css_w, busy_w, done_w, mode_w, simo_w}), 512'(10'b11_00_00_00_00));
        check("midreset_result", 512'(res_w), 512'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(128'h00112233445566778899aabbccddeeff,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 0, 1'b0);
        run_txn(rnd128(), {rnd128(), rnd128()}, rnd128(), 0, 1'b1);

        repeat (20) @(negedge clk);
        check("sb_drained", 512'({sb_a.size(), sb_b.size()}), 512'(0));
        check("txn_count_a", 512'(n_done[0]), 512'(n_exp));
        check("txn_count_b", 512'(n_done[1]), 512'(n_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
